// File: rtl/if_fetch.sv
// Instruction fetch stage: byte-serial memory fill behind a direct-mapped
// one-word-per-line instruction cache, valid/ready output to IF/ID.
module if_fetch #(
  parameter int CACHE_LINES = 16,
  parameter int ADDR_W      = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc_in,
  input  logic        jmp_tak,
  output logic        stall_req,
  output logic        mem_req,
  output logic [31:0] mem_a,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_din,
  output logic        inst_valid,
  input  logic        id_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t           state;
  logic [31:0]      req_pc;
  logic [2:0]       iss;
  logic [1:0]       rcv;
  logic             pend;
  logic [23:0]      word_q;

  logic [CACHE_LINES-1:0] c_vld;
  logic [TAG_W-1:0]       c_tag [CACHE_LINES];
  logic [31:0]            c_dat [CACHE_LINES];

  logic [IDX_W-1:0] idx_in;
  logic [TAG_W-1:0] tag_in;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             slot_free;
  logic             accept;
  logic             flush;
  logic             done;
  logic [31:0]      full_word;
  logic [31:0]      pc_al;

  assign idx_in    = pc_in[2+IDX_W-1:2];
  assign tag_in    = pc_in[ADDR_W-1:2+IDX_W];
  assign req_idx   = req_pc[2+IDX_W-1:2];
  assign req_tag   = req_pc[ADDR_W-1:2+IDX_W];
  assign pc_al     = pc_in & 32'hFFFF_FFFC;
  assign hit       = c_vld[idx_in] && (c_tag[idx_in] == tag_in);
  assign slot_free = !inst_valid || id_ready;
  assign accept    = (state == S_IDLE) && rdy_in && !jmp_tak
                     && slot_free;
  assign flush     = rdy_in && jmp_tak;
  assign done      = (state == S_FETCH) && pend && (rcv == 2'd3);
  assign full_word = {mem_din, word_q};

  assign mem_req = (state == S_FETCH) && !iss[2];
  assign mem_a   = {req_pc[31:2], iss[1:0]};

  // Idle term covers both backpressure and the miss-accept cycle.
  assign stall_req = rst_in && (
    ((state == S_FETCH) && !flush) ||
    ((state == S_IDLE) && rdy_in && !jmp_tak &&
     (!slot_free || (accept && !hit))));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= S_IDLE;
      req_pc     <= '0;
      iss        <= '0;
      rcv        <= '0;
      pend       <= 1'b0;
      word_q     <= '0;
      c_vld      <= '0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
    end else if (rdy_in) begin
      if (inst_valid && id_ready)
        inst_valid <= 1'b0;
      if (jmp_tak) begin
        state      <= S_IDLE;
        inst_valid <= 1'b0;
        pend       <= 1'b0;
        iss        <= '0;
        rcv        <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (accept) begin
              req_pc <= pc_al;
              if (hit) begin
                inst_valid <= 1'b1;
                inst_out   <= c_dat[idx_in];
                inst_pc    <= pc_al;
              end else begin
                state <= S_FETCH;
                iss   <= '0;
                rcv   <= '0;
                pend  <= 1'b0;
              end
            end
          end
          S_FETCH: begin
            if (mem_req && mem_gnt)
              iss <= iss + 3'd1;
            pend <= mem_req && mem_gnt;
            if (pend) begin
              rcv <= rcv + 2'd1;
              unique case (rcv)
                2'd0:    word_q[7:0]   <= mem_din;
                2'd1:    word_q[15:8]  <= mem_din;
                2'd2:    word_q[23:16] <= mem_din;
                default: ;
              endcase
            end
            if (done) begin
              c_vld[req_idx] <= 1'b1;
              inst_valid     <= 1'b1;
              inst_out       <= full_word;
              inst_pc        <= req_pc;
              state          <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && !jmp_tak && done) begin
      c_tag[req_idx] <= req_tag;
      c_dat[req_idx] <= full_word;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a byte-wide memory responder
// that returns data one cycle after each granted request.
module tb_if_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] pc_in;
  logic        jmp_tak;
  logic        stall_req;
  logic        mem_req;
  logic [31:0] mem_a;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic        inst_valid;
  logic        id_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  int checks = 0;
  int failures = 0;

  if_fetch dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .pc_in     (pc_in),
    .jmp_tak   (jmp_tak),
    .stall_req (stall_req),
    .mem_req   (mem_req),
    .mem_a     (mem_a),
    .mem_gnt   (mem_gnt),
    .mem_din   (mem_din),
    .inst_valid(inst_valid),
    .id_ready  (id_ready),
    .inst_out  (inst_out),
    .inst_pc   (inst_pc)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] memw(input logic [31:0] a);
    logic [31:0] w;
    case (a & 32'hFFFF_FFFC)
      32'h0000_0000: w = 32'h0010_0513;
      32'h0000_0004: w = 32'h0020_0593;
      32'h0000_0008: w = 32'h0030_0613;
      32'h0000_0040: w = 32'hDEAD_BEEF;
      32'h0000_0100: w = 32'h1234_5678;
      32'h0000_0200: w = 32'h0BAD_F00D;
      32'hFFFF_FFFC: w = 32'hCAFE_F00D;
      default:       w = a ^ 32'h5A5A_5A5A;
    endcase
    return w;
  endfunction

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [31:0] w;
    w = memw(a);
    return w[8*a[1:0] +: 8];
  endfunction

  always @(posedge clk_in)
    if (rdy_in && mem_req && mem_gnt)
      mem_din <= mb(mem_a);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Accept pc as a miss, then count edges until inst_valid.
  task automatic miss(input logic [31:0] pc, input int lat,
                      input int g_lo, input int g_hi);
    int n;
    int sc;
    logic [31:0] pa;
    pa = pc & 32'hFFFF_FFFC;
    pc_in = pc;
    id_ready = 1'b1;
    #1;
    chk("acc_stall", {31'd0, stall_req}, 32'd1);
    chk("acc_memreq", {31'd0, mem_req}, 32'd0);
    step();
    id_ready = 1'b0;
    n = 0;
    sc = 0;
    while (!inst_valid && n < 40) begin
      mem_gnt = (n >= g_lo && n <= g_hi) ? 1'b0 : 1'b1;
      #1;
      if (n >= g_lo && n <= g_hi)
        chk("hold_mem_a", mem_a, pa | 32'd1);
      if (stall_req)
        sc++;
      step();
      n++;
    end
    mem_gnt = 1'b1;
    chk("miss_lat", n, lat);
    chk("miss_stall_cyc", sc, lat);
    chk("miss_inst", inst_out, memw(pa));
    chk("miss_pc", inst_pc, pa);
    chk("hold_stall", {31'd0, stall_req}, 32'd1);
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    pc_in = 32'h0;
    jmp_tak = 1'b0;
    mem_gnt = 1'b1;
    id_ready = 1'b1;
    #2;
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    step();
    step();
    rst_in = 1'b1;

    miss(32'h0, 5, 99, 99);
    miss(32'h4, 5, 99, 99);
    miss(32'h8, 5, 99, 99);

    id_ready = 1'b1;
    pc_in = 32'h0;
    #1;
    chk("hit0_stall", {31'd0, stall_req}, 32'd0);
    chk("hit0_memreq", {31'd0, mem_req}, 32'd0);
    step();
    chk("hit0_valid", {31'd0, inst_valid}, 32'd1);
    chk("hit0_inst", inst_out, 32'h0010_0513);
    chk("hit0_pc", inst_pc, 32'h0);
    pc_in = 32'h4;
    #1;
    chk("hit4_stall", {31'd0, stall_req}, 32'd0);
    step();
    chk("hit4_valid", {31'd0, inst_valid}, 32'd1);
    chk("hit4_inst", inst_out, 32'h0020_0593);
    chk("hit4_pc", inst_pc, 32'h4);
    pc_in = 32'h8;
    #1;
    chk("hit8_stall", {31'd0, stall_req}, 32'd0);
    chk("hit8_memreq", {31'd0, mem_req}, 32'd0);
    step();
    id_ready = 1'b0;
    chk("hit8_inst", inst_out, 32'h0030_0613);
    chk("hit8_pc", inst_pc, 32'h8);

    pc_in = 32'h40;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_stall", {31'd0, stall_req}, 32'd1);
      chk("bp_inst", inst_out, 32'h0030_0613);
      chk("bp_pc", inst_pc, 32'h8);
      chk("bp_memreq", {31'd0, mem_req}, 32'd0);
      step();
    end
    rdy_in = 1'b0;
    id_ready = 1'b1;
    step();
    rdy_in = 1'b1;
    chk("frz_valid", {31'd0, inst_valid}, 32'd1);
    chk("frz_pc", inst_pc, 32'h8);

    #1;
    chk("fl_acc_stall", {31'd0, stall_req}, 32'd1);
    step();
    id_ready = 1'b0;
    chk("fl_memreq", {31'd0, mem_req}, 32'd1);
    chk("fl_valid", {31'd0, inst_valid}, 32'd0);
    step();
    step();
    step();
    jmp_tak = 1'b1;
    pc_in = 32'h100;
    #1;
    chk("fl_stall", {31'd0, stall_req}, 32'd0);
    step();
    jmp_tak = 1'b0;
    chk("fl_after_valid", {31'd0, inst_valid}, 32'd0);
    chk("fl_after_memreq", {31'd0, mem_req}, 32'd0);
    miss(32'h100, 5, 99, 99);
    miss(32'h42, 5, 99, 99);
    miss(32'hFFFF_FFFC, 5, 99, 99);
    miss(32'h0, 5, 99, 99);

    id_ready = 1'b1;
    pc_in = 32'h0;
    #1;
    chk("rehit_stall", {31'd0, stall_req}, 32'd0);
    step();
    chk("rehit_inst", inst_out, 32'h0010_0513);

    pc_in = 32'h200;
    step();
    step();
    chk("ar_memreq_pre", {31'd0, mem_req}, 32'd1);
    #2;
    rst_in = 1'b0;
    #1;
    chk("ar_memreq", {31'd0, mem_req}, 32'd0);
    chk("ar_stall", {31'd0, stall_req}, 32'd0);
    chk("ar_valid", {31'd0, inst_valid}, 32'd0);
    chk("ar_mem_a", mem_a, 32'd0);
    step();
    rst_in = 1'b1;

    miss(32'h0, 8, 1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
